// File: rtl/accelerator_hls_deadlock_pkg.sv
// Shared types and constants for the HLS deadlock report unit.
package accelerator_hls_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REPORT = 2'd1,
    HOLD   = 2'd2
  } dl_state_t;

  localparam int DL_COUNT_W = 8;
  localparam logic [DL_COUNT_W-1:0] DL_COUNT_MAX = 8'd255;

endpackage

// File: rtl/accelerator_hls_deadlock_persist_cnt.sv
// Persistence filter for one monitor block bit: qual rises once the bit has
// been high for PERSIST consecutive edges, and any low cycle restarts the count.
module accelerator_hls_deadlock_persist_cnt #(
  parameter int PERSIST = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic block,
  output logic qual
);

  localparam int C_W = $clog2(PERSIST + 1);
  localparam logic [C_W-1:0] C_MAX = C_W'(PERSIST);

  logic [C_W-1:0] count;

  // Saturates at PERSIST so a long-held block never wraps back below threshold.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (!block) begin
      count <= '0;
    end else if (count != C_MAX) begin
      count <= count + C_W'(1);
    end
  end

  assign qual = (count == C_MAX);

endmodule

// File: rtl/accelerator_hls_deadlock_report_unit.sv
// Qualifies HLS deadlock monitor block bits, latches a single report and
// presents it on a valid/ready port alongside a sticky deadlock flag.
module accelerator_hls_deadlock_report_unit
  import accelerator_hls_deadlock_pkg::*;
#(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = 2,
  parameter int PERSIST = 16,
  parameter int CNT_W   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_MON-1:0]    block_sigs,
  input  logic                  clear,
  output logic                  rpt_valid,
  input  logic                  rpt_ready,
  output logic [IDX_W-1:0]      rpt_idx,
  output logic [NUM_MON-1:0]    rpt_mask,
  output logic [CNT_W-1:0]      rpt_time,
  output logic                  deadlock,
  output logic [DL_COUNT_W-1:0] dl_count
);

  logic [NUM_MON-1:0] qual;
  logic [CNT_W-1:0]   ts;
  logic [IDX_W-1:0]   first_idx;
  logic               capture;
  dl_state_t          state_q;
  dl_state_t          state_d;

  for (genvar g = 0; g < NUM_MON; g++) begin : g_persist
    accelerator_hls_deadlock_persist_cnt #(
      .PERSIST(PERSIST)
    ) u_persist (
      .clock(clock),
      .reset(reset),
      .block(block_sigs[g]),
      .qual (qual[g])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ts <= '0;
    end else begin
      ts <= ts + CNT_W'(1);
    end
  end

  // Scan from the top down so the lowest qualified index is the one left standing.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (qual[i]) begin
        first_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // HOLD waits for every qualifier to drop so a persisting block is reported once.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    rpt_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (|qual) begin
          state_d = REPORT;
          capture = 1'b1;
        end
      end
      REPORT: begin
        rpt_valid = 1'b1;
        if (rpt_ready) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (qual == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rpt_idx  <= '0;
      rpt_mask <= '0;
      rpt_time <= '0;
    end else if (capture) begin
      rpt_idx  <= first_idx;
      rpt_mask <= qual;
      rpt_time <= ts;
    end
  end

  // A capture on the same edge as clear wins, so a fresh deadlock is never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      deadlock <= 1'b0;
    end else if (capture) begin
      deadlock <= 1'b1;
    end else if (clear) begin
      deadlock <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dl_count <= '0;
    end else if (capture && (dl_count != DL_COUNT_MAX)) begin
      dl_count <= dl_count + DL_COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_accelerator_hls_deadlock_report_unit.sv
// Directed bench for the deadlock report unit: a PERSIST=4 instance driven from a
// vector table plus hand sequences, and a PERSIST=1 instance for latency and saturation.
module tb_accelerator_hls_deadlock_report_unit;

  logic        clock;
  logic        reset;

  logic [3:0]  block0;
  logic        clear0;
  logic        ready0;
  logic        valid0;
  logic [1:0]  idx0;
  logic [3:0]  mask0;
  logic [31:0] time0;
  logic        dl0;
  logic [7:0]  cnt0;

  logic [3:0]  block1;
  logic        clear1;
  logic        ready1;
  logic        valid1;
  logic [1:0]  idx1;
  logic [3:0]  mask1;
  logic [31:0] time1;
  logic        dl1;
  logic [7:0]  cnt1;

  int total;
  int bad;
  int tb_ts;
  int cap_ts;

  typedef struct {
    logic [3:0] blk;
    logic       clr;
    logic       rdy;
    logic       v;
    logic [1:0] idx;
    logic [3:0] mask;
    logic       dl;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  accelerator_hls_deadlock_report_unit #(
    .NUM_MON(4), .IDX_W(2), .PERSIST(4), .CNT_W(32)
  ) u0 (
    .clock(clock), .reset(reset), .block_sigs(block0), .clear(clear0),
    .rpt_valid(valid0), .rpt_ready(ready0), .rpt_idx(idx0), .rpt_mask(mask0),
    .rpt_time(time0), .deadlock(dl0), .dl_count(cnt0)
  );

  accelerator_hls_deadlock_report_unit #(
    .NUM_MON(4), .IDX_W(2), .PERSIST(1), .CNT_W(32)
  ) u1 (
    .clock(clock), .reset(reset), .block_sigs(block1), .clear(clear1),
    .rpt_valid(valid1), .rpt_ready(ready1), .rpt_idx(idx1), .rpt_mask(mask1),
    .rpt_time(time1), .deadlock(dl1), .dl_count(cnt1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle with the given u0 inputs; outputs are sampled 1ns after the edge.
  task automatic apply_stimulus(input logic [3:0] blk, input logic clr, input logic rdy);
    block0 = blk;
    clear0 = clr;
    ready0 = rdy;
    @(posedge clock);
    #1;
    tb_ts++;
  endtask

  task automatic push_vec(input int n, input logic [3:0] blk, input logic clr, input logic rdy,
                          input logic v, input logic [1:0] idx, input logic [3:0] mask,
                          input logic dl, input logic [7:0] cnt);
    vec_t r;
    r.blk = blk; r.clr = clr; r.rdy = rdy; r.v = v;
    r.idx = idx; r.mask = mask; r.dl = dl; r.cnt = cnt;
    for (int k = 0; k < n; k++) tbl.push_back(r);
  endtask

  task automatic do_reset();
    block0 = '0; clear0 = 0; ready0 = 0;
    block1 = '0; clear1 = 0; ready1 = 0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    tb_ts = 0;
  endtask

  initial begin
    int ts_before;
    total = 0;
    bad   = 0;
    tb_ts = 0;
    reset = 1'b1;
    block0 = '0; clear0 = 0; ready0 = 0;
    block1 = '0; clear1 = 0; ready1 = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    tb_ts = 0;

    check_output("reset_valid", 32'(valid0), 32'd0);
    check_output("reset_deadlock", 32'(dl0), 32'd0);
    check_output("reset_count", 32'(cnt0), 32'd0);
    check_output("reset_time", time0, 32'd0);
    check_output("reset_mask", 32'(mask0), 32'd0);

    // Rows start at ts=0; comments give the ts of the first row in each group.
    push_vec(10, 4'b0000, 0, 0, 0, 2'd0, 4'b0000, 0, 8'd0);   // ts 0
    push_vec(4,  4'b0100, 0, 0, 0, 2'd0, 4'b0000, 0, 8'd0);   // ts 10
    push_vec(1,  4'b0100, 0, 0, 1, 2'd2, 4'b0100, 1, 8'd1);   // ts 14 capture
    push_vec(1,  4'b0100, 0, 1, 0, 2'd0, 4'b0000, 1, 8'd1);   // ts 15
    push_vec(2,  4'b0000, 0, 0, 0, 2'd0, 4'b0000, 1, 8'd1);   // ts 16
    push_vec(4,  4'b1010, 0, 0, 0, 2'd0, 4'b0000, 1, 8'd1);   // ts 18
    push_vec(1,  4'b1010, 0, 0, 1, 2'd1, 4'b1010, 1, 8'd2);   // ts 22 capture
    push_vec(1,  4'b0000, 0, 1, 0, 2'd0, 4'b0000, 1, 8'd2);   // ts 23
    push_vec(1,  4'b0000, 0, 0, 0, 2'd0, 4'b0000, 1, 8'd2);   // ts 24
    push_vec(3,  4'b0001, 0, 0, 0, 2'd0, 4'b0000, 1, 8'd2);   // ts 25
    push_vec(1,  4'b0000, 0, 0, 0, 2'd0, 4'b0000, 1, 8'd2);   // ts 28 dropout
    push_vec(4,  4'b0001, 0, 0, 0, 2'd0, 4'b0000, 1, 8'd2);   // ts 29
    push_vec(1,  4'b0001, 0, 0, 1, 2'd0, 4'b0001, 1, 8'd3);   // ts 33 capture
    push_vec(1,  4'b0000, 0, 1, 0, 2'd0, 4'b0000, 1, 8'd3);   // ts 34
    push_vec(1,  4'b0000, 0, 0, 0, 2'd0, 4'b0000, 1, 8'd3);   // ts 35
    push_vec(1,  4'b0000, 1, 0, 0, 2'd0, 4'b0000, 0, 8'd3);   // ts 36 clear

    foreach (tbl[i]) begin
      ts_before = tb_ts;
      apply_stimulus(tbl[i].blk, tbl[i].clr, tbl[i].rdy);
      check_output($sformatf("vec%0d_valid", i), 32'(valid0), 32'(tbl[i].v));
      check_output($sformatf("vec%0d_deadlock", i), 32'(dl0), 32'(tbl[i].dl));
      check_output($sformatf("vec%0d_count", i), 32'(cnt0), 32'(tbl[i].cnt));
      if (tbl[i].v) begin
        check_output($sformatf("vec%0d_idx", i), 32'(idx0), 32'(tbl[i].idx));
        check_output($sformatf("vec%0d_mask", i), 32'(mask0), 32'(tbl[i].mask));
        check_output($sformatf("vec%0d_time", i), time0, 32'(ts_before));
      end
    end

    // Stalled consumer: bit 0 reports, bit 2 qualifies meanwhile and is ignored.
    for (int k = 0; k < 4; k++) apply_stimulus(4'b0001, 0, 0);
    cap_ts = tb_ts;
    apply_stimulus(4'b0001, 0, 0);
    check_output("stall_cap_valid", 32'(valid0), 32'd1);
    check_output("stall_cap_count", 32'(cnt0), 32'd4);
    for (int k = 0; k < 20; k++) begin
      apply_stimulus(4'b0101, 0, 0);
      check_output($sformatf("stall%0d_valid", k), 32'(valid0), 32'd1);
      check_output($sformatf("stall%0d_idx", k), 32'(idx0), 32'd0);
      check_output($sformatf("stall%0d_mask", k), 32'(mask0), 32'h1);
      check_output($sformatf("stall%0d_time", k), time0, 32'(cap_ts));
    end
    apply_stimulus(4'b0101, 0, 1);
    check_output("hold_valid", 32'(valid0), 32'd0);
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(4'b0101, 0, 0);
      check_output($sformatf("hold%0d_valid", k), 32'(valid0), 32'd0);
    end
    check_output("hold_count", 32'(cnt0), 32'd4);
    apply_stimulus(4'b0000, 0, 0);
    for (int k = 0; k < 4; k++) apply_stimulus(4'b0100, 0, 0);
    check_output("rearm_early_valid", 32'(valid0), 32'd0);
    cap_ts = tb_ts;
    apply_stimulus(4'b0100, 0, 0);
    check_output("rearm_valid", 32'(valid0), 32'd1);
    check_output("rearm_idx", 32'(idx0), 32'd2);
    check_output("rearm_mask", 32'(mask0), 32'h4);
    check_output("rearm_time", time0, 32'(cap_ts));
    check_output("rearm_count", 32'(cnt0), 32'd5);

    // Clear on the capture edge loses to the capture; a later clear wins.
    apply_stimulus(4'b0000, 1, 1);
    check_output("clr_hold_deadlock", 32'(dl0), 32'd0);
    apply_stimulus(4'b0000, 0, 0);
    for (int k = 0; k < 4; k++) apply_stimulus(4'b0010, 0, 0);
    check_output("clr_pre_deadlock", 32'(dl0), 32'd0);
    apply_stimulus(4'b0010, 1, 0);
    check_output("clr_cap_deadlock", 32'(dl0), 32'd1);
    check_output("clr_cap_valid", 32'(valid0), 32'd1);
    check_output("clr_cap_idx", 32'(idx0), 32'd1);
    check_output("clr_cap_count", 32'(cnt0), 32'd6);
    apply_stimulus(4'b0010, 1, 0);
    check_output("clr_late_deadlock", 32'(dl0), 32'd0);
    check_output("clr_late_valid", 32'(valid0), 32'd1);
    check_output("clr_late_count", 32'(cnt0), 32'd6);

    // Reset while the report is pending, then confirm ts restarted from 0.
    do_reset();
    check_output("rst_mid_valid", 32'(valid0), 32'd0);
    check_output("rst_mid_deadlock", 32'(dl0), 32'd0);
    check_output("rst_mid_count", 32'(cnt0), 32'd0);
    check_output("rst_mid_time", time0, 32'd0);
    check_output("rst_mid_idx", 32'(idx0), 32'd0);
    for (int k = 0; k < 4; k++) apply_stimulus(4'b1000, 0, 0);
    apply_stimulus(4'b1000, 0, 0);
    check_output("post_rst_valid", 32'(valid0), 32'd1);
    check_output("post_rst_time", time0, 32'd4);
    check_output("post_rst_idx", 32'(idx0), 32'd3);
    check_output("post_rst_count", 32'(cnt0), 32'd1);
    apply_stimulus(4'b0000, 0, 1);
    apply_stimulus(4'b0000, 0, 0);

    // PERSIST=1: one high edge qualifies, capture on the next; then saturate dl_count.
    block1 = 4'b0001;
    apply_stimulus(4'b0000, 0, 0);
    check_output("p1_first_valid", 32'(valid1), 32'd0);
    cap_ts = tb_ts;
    apply_stimulus(4'b0000, 0, 0);
    check_output("p1_cap_valid", 32'(valid1), 32'd1);
    check_output("p1_cap_idx", 32'(idx1), 32'd0);
    check_output("p1_cap_time", time1, 32'(cap_ts));
    check_output("p1_cap_count", 32'(cnt1), 32'd1);
    for (int n = 0; n < 260; n++) begin
      block1 = 4'b0000; ready1 = 1'b1;
      apply_stimulus(4'b0000, 0, 0);
      ready1 = 1'b0;
      apply_stimulus(4'b0000, 0, 0);
      block1 = 4'b0001;
      apply_stimulus(4'b0000, 0, 0);
      apply_stimulus(4'b0000, 0, 0);
      check_output($sformatf("p1_sat%0d_count", n), 32'(cnt1), (n + 2 > 255) ? 32'd255 : 32'(n + 2));
    end
    check_output("p1_sat_valid", 32'(valid1), 32'd1);
    check_output("p1_sat_deadlock", 32'(dl1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
